// File: rtl/fifo_readout_serializer.sv
// Reads words from the readout FIFO with an active-low read strobe and sends
// each one out as a serial frame: start 0, data LSB first, odd parity, stop 1.
module fifo_readout_serializer #(
    parameter int WORD_WIDTH   = 63,
    parameter int CLKS_PER_BIT = 1,
    parameter int READ_PULSE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic                  read_n,
    output logic                  tx_data,
    output logic                  tx_busy,
    output logic [15:0]           frame_count
);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int PW = $clog2(READ_PULSE + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PUL_LAST = PW'(READ_PULSE - 1);

    typedef enum logic [2:0] {IDLE, READ, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic                  empty_q, empty_s;
    logic [WORD_WIDTH-1:0] shreg, shreg_nx;
    logic                  par, par_nx;
    logic [BW-1:0]         bit_cnt, bit_nx;
    logic [CW-1:0]         cyc_cnt, cyc_nx;
    logic [PW-1:0]         pul_cnt, pul_nx;
    logic                  read_n_nx, tx_nx, busy_nx;
    logic [15:0]           count_nx;
    logic                  bit_end;

    // The empty flag comes from another clock domain; only empty_s is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            empty_q <= 1'b1;
            empty_s <= 1'b1;
        end else begin
            empty_q <= fifo_empty;
            empty_s <= empty_q;
        end
    end

    // State and all registered outputs; outputs never see inputs combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            par         <= 1'b0;
            bit_cnt     <= '0;
            cyc_cnt     <= '0;
            pul_cnt     <= '0;
            read_n      <= 1'b1;
            tx_data     <= 1'b1;
            tx_busy     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            par         <= par_nx;
            bit_cnt     <= bit_nx;
            cyc_cnt     <= cyc_nx;
            pul_cnt     <= pul_nx;
            read_n      <= read_n_nx;
            tx_data     <= tx_nx;
            tx_busy     <= busy_nx;
            frame_count <= count_nx;
        end
    end

    assign bit_end = (cyc_cnt == CYC_LAST);

    // Next-state: each serial bit is held CLKS_PER_BIT cycles; the line value
    // for the next bit is loaded on the last cycle of the current one.
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        par_nx    = par;
        bit_nx    = bit_cnt;
        cyc_nx    = cyc_cnt;
        pul_nx    = pul_cnt;
        read_n_nx = read_n;
        tx_nx     = tx_data;
        busy_nx   = tx_busy;
        count_nx  = frame_count;
        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (enable && !empty_s) begin
                    state_nx  = READ;
                    read_n_nx = 1'b0;
                    busy_nx   = 1'b1;
                    pul_nx    = '0;
                end
            end
            READ: begin
                if (pul_cnt == PUL_LAST) begin
                    shreg_nx  = fifo_data;
                    par_nx    = ~^fifo_data;
                    read_n_nx = 1'b1;
                    tx_nx     = 1'b0;
                    cyc_nx    = '0;
                    state_nx  = START;
                end else begin
                    pul_nx = pul_cnt + 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cyc_nx   = '0;
                    bit_nx   = '0;
                    tx_nx    = shreg[0];
                    state_nx = DATA;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_nx    = par;
                        state_nx = PARITY;
                    end else begin
                        shreg_nx = shreg >> 1;
                        tx_nx    = shreg_nx[0];
                        bit_nx   = bit_cnt + 1'b1;
                    end
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cyc_nx   = '0;
                    tx_nx    = 1'b1;
                    state_nx = STOP;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_nx   = '0;
                    count_nx = frame_count + 16'd1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_readout_serializer.sv
// Directed bench: instance a uses default parameters with a queue FIFO model,
// instance b runs CLKS_PER_BIT=4 for the slow-rate and counter-wrap cases.
module tb_fifo_readout_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_a = 1'b0, empty_a = 1'b1;
    logic [62:0] data_a = '0;
    logic        read_n_a, tx_a, busy_a;
    logic [15:0] count_a;
    logic        enable_b = 1'b0, empty_b = 1'b1;
    logic [62:0] data_b = '0;
    logic        read_n_b, tx_b, busy_b;
    logic [15:0] count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [62:0] d;
        logic        p;
        logic        s;
        bit          g;
    } frm_t;
    frm_t        rxa[$], rxb[$];
    logic [62:0] fq[$];
    int          fall_t[$], low_len[$];
    logic        rn_prev = 1'b1;
    int          low_start = 0;
    int          fall_b = 0, busy_end_b = 0;
    logic        rnb_prev = 1'b1, busyb_prev = 1'b0;

    fifo_readout_serializer dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .fifo_empty(empty_a),
        .fifo_data(data_a), .read_n(read_n_a), .tx_data(tx_a),
        .tx_busy(busy_a), .frame_count(count_a)
    );

    fifo_readout_serializer #(.WORD_WIDTH(63), .CLKS_PER_BIT(4), .READ_PULSE(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .fifo_empty(empty_b),
        .fifo_data(data_b), .read_n(read_n_b), .tx_data(tx_b),
        .tx_busy(busy_b), .frame_count(count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic fifo_upd();
        empty_a = (fq.size() == 0);
        data_a  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [62:0] w);
        fq.push_back(w);
        fifo_upd();
    endtask

    // FIFO model: word retires when the read strobe returns high.
    always @(posedge read_n_a) begin
        if (fq.size() != 0) void'(fq.pop_front());
        fifo_upd();
    end

    // Read strobe timing of instance a, in clock numbers.
    always @(negedge clk) begin
        if (rn_prev && !read_n_a) begin
            fall_t.push_back(cyc);
            low_start = cyc;
        end
        if (!rn_prev && read_n_a) low_len.push_back(cyc - low_start);
        rn_prev = read_n_a;
        if (rnb_prev && !read_n_b) fall_b = cyc;
        if (busyb_prev && !busy_b) busy_end_b = cyc;
        rnb_prev   = read_n_b;
        busyb_prev = busy_b;
    end

    // Sample every cycle of a frame; flag any bit that changes within its slot.
    task automatic rx_frame(input bit which, input int cpb, output frm_t f);
        logic [65:0] bits;
        logic        b;
        bits = '0;
        f.g  = 1'b0;
        for (int k = 0; k < 66; k++) begin
            for (int c = 0; c < cpb; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                b = which ? tx_b : tx_a;
                if (c == 0) bits[k] = b;
                else if (b !== bits[k]) f.g = 1'b1;
            end
        end
        f.d = bits[63:1];
        f.p = bits[64];
        f.s = bits[65];
    endtask

    always begin : mon_a
        frm_t f;
        @(negedge clk);
        if (!reset && tx_a === 1'b0) begin
            rx_frame(1'b0, 1, f);
            rxa.push_back(f);
        end
    end

    always begin : mon_b
        frm_t f;
        @(negedge clk);
        if (!reset && tx_b === 1'b0) begin
            rx_frame(1'b1, 4, f);
            rxb.push_back(f);
        end
    end

    task automatic wait_rx(input bit which, input int n);
        int budget = 3000;
        while (((which ? rxb.size() : rxa.size()) < n) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("rx_timeout", 64'(budget > 0), 64'd1);
    endtask

    task automatic chk_frame(input string tag, input bit which, input int idx,
                             input logic [62:0] d, input logic p);
        frm_t f;
        if ((which ? rxb.size() : rxa.size()) <= idx) begin
            chk({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            f = which ? rxb[idx] : rxa[idx];
            chk({tag, "_data"}, 64'(f.d), 64'(d));
            chk({tag, "_par"}, 64'(f.p), 64'(p));
            chk({tag, "_stop"}, 64'(f.s), 64'd1);
            chk({tag, "_glitch"}, 64'(f.g), 64'd0);
        end
    endtask

    task automatic clear_logs();
        rxa.delete();
        fall_t.delete();
        low_len.delete();
    endtask

    logic [62:0] w4[4];
    logic        p4[4];
    int          c0;
    int          budget;

    initial begin
        w4 = '{63'h5, 63'h7, 63'h4000_0000_0000_0000, 63'hFF};
        p4 = '{1'b1, 1'b0, 1'b0, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_read_n", 64'(read_n_a), 64'd1);
        chk("rst_tx", 64'(tx_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_count", 64'(count_a), 64'd0);
        reset = 1'b0;
        enable_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_empty_busy", 64'(busy_a), 64'd0);
        chk("idle_empty_read_n", 64'(read_n_a), 64'd1);

        // single word 1
        clear_logs();
        push(63'h1);
        wait_rx(1'b0, 1);
        repeat (3) @(negedge clk);
        chk_frame("one", 1'b0, 0, 63'h1, 1'b0);
        chk("one_low_len", 64'(low_len.size() > 0 ? low_len[0] : 0), 64'd2);
        chk("one_count", 64'(count_a), 64'd1);
        chk("one_idle_busy", 64'(busy_a), 64'd0);

        // parity cases
        clear_logs();
        push(63'h0);
        push(63'h7FFF_FFFF_FFFF_FFFF);
        push(63'h3);
        wait_rx(1'b0, 3);
        repeat (3) @(negedge clk);
        chk_frame("par_zero", 1'b0, 0, 63'h0, 1'b1);
        chk_frame("par_ones", 1'b0, 1, 63'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        chk_frame("par_three", 1'b0, 2, 63'h3, 1'b1);
        chk("par_count", 64'(count_a), 64'd4);

        // back-to-back, 69-cycle read period
        repeat (5) @(negedge clk);
        clear_logs();
        for (int i = 0; i < 4; i++) push(w4[i]);
        wait_rx(1'b0, 4);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_frame($sformatf("b2b%0d", i), 1'b0, i, w4[i], p4[i]);
        chk("b2b_reads", 64'(fall_t.size()), 64'd4);
        for (int i = 0; i < 3 && i + 1 < fall_t.size(); i++)
            chk($sformatf("b2b_period%0d", i), 64'(fall_t[i+1] - fall_t[i]), 64'd69);
        for (int i = 0; i < low_len.size(); i++)
            chk($sformatf("b2b_low%0d", i), 64'(low_len[i]), 64'd2);
        chk("b2b_count", 64'(count_a), 64'd8);
        chk("b2b_idle", 64'(busy_a), 64'd0);

        // enable dropped during the second frame
        clear_logs();
        push(63'h1);
        push(63'h3);
        push(63'hF);
        budget = 500;
        while (fall_t.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("en_second_read", 64'(budget > 0), 64'd1);
        enable_a = 1'b0;
        wait_rx(1'b0, 2);
        repeat (100) @(negedge clk);
        chk("en_no_third", 64'(fall_t.size()), 64'd2);
        chk("en_off_busy", 64'(busy_a), 64'd0);
        chk("en_off_count", 64'(count_a), 64'd10);
        chk_frame("en0", 1'b0, 0, 63'h1, 1'b0);
        chk_frame("en1", 1'b0, 1, 63'h3, 1'b1);
        c0 = cyc;
        enable_a = 1'b1;
        wait_rx(1'b0, 3);
        repeat (3) @(negedge clk);
        chk("en_resume_time", 64'(fall_t.size() > 2 ? fall_t[2] : 0), 64'(c0 + 1));
        chk_frame("en2", 1'b0, 2, 63'hF, 1'b1);
        chk("en_count", 64'(count_a), 64'd11);

        // reset in the middle of the data field
        push(63'h3);
        budget = 100;
        while (read_n_a !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("mid_read_seen", 64'(budget > 0), 64'd1);
        repeat (10) @(negedge clk);
        chk("mid_busy_before", 64'(busy_a), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_read_n", 64'(read_n_a), 64'd1);
        chk("mid_rst_tx", 64'(tx_a), 64'd1);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_count", 64'(count_a), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_rst_busy", 64'(busy_a), 64'd0);
        chk("post_rst_read_n", 64'(read_n_a), 64'd1);
        chk("post_rst_tx", 64'(tx_a), 64'd1);

        // slow bit rate and frame counter wrap on instance b
        force dut_b.frame_count = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut_b.frame_count;
        @(negedge clk);
        chk("wrap_preset", 64'(count_b), 64'hFFFF);
        data_b   = 63'hA5;
        empty_b  = 1'b0;
        enable_b = 1'b1;
        budget = 100;
        while (read_n_b !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("slow_read_seen", 64'(budget > 0), 64'd1);
        empty_b = 1'b1;
        wait_rx(1'b1, 1);
        repeat (8) @(negedge clk);
        chk_frame("slow", 1'b1, 0, 63'hA5, 1'b1);
        chk("slow_frame_len", 64'(busy_end_b - fall_b), 64'd266);
        chk("wrap_count", 64'(count_b), 64'd0);
        chk("slow_idle", 64'(busy_b), 64'd0);
        chk("slow_one_read", 64'(read_n_b), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
